// File: rtl/stack_seq_if.sv
// Stack sequencer bus: SP command type, control-unit request/response and byte-wide memory port.
package stack_seq_pkg;
    typedef enum logic [2:0] {
        SP_NOP   = 3'd0,
        SP_INC_1 = 3'd1,
        SP_INC_2 = 3'd2,
        SP_DEC_1 = 3'd3,
        SP_DEC_2 = 3'd4
    } sp_operation_t;
endpackage

interface stack_seq_if #(
    parameter int ADDR_W = 14
);
    import stack_seq_pkg::*;

    logic                req;
    logic [1:0]          op;
    logic [15:0]         wdata;
    logic [ADDR_W-1:0]   sp_addr;
    logic                ready;
    logic                done;
    logic                err;
    logic [15:0]         rdata;
    logic [ADDR_W-1:0]   mem_addr;
    logic [7:0]          mem_wdata;
    logic                mem_we;
    logic                mem_re;
    logic [7:0]          mem_rdata;
    sp_operation_t       sp_operation;

    // Control unit, SP register and memory side
    modport master (
        output req, op, wdata, sp_addr, mem_rdata,
        input  ready, done, err, rdata, mem_addr, mem_wdata, mem_we, mem_re, sp_operation
    );

    // Sequencer side
    modport slave (
        input  req, op, wdata, sp_addr, mem_rdata,
        output ready, done, err, rdata, mem_addr, mem_wdata, mem_we, mem_re, sp_operation
    );
endinterface

// File: rtl/stack_seq.sv
// Stack access sequencer: runs 8/16-bit PUSH/POP as byte-wide memory cycles,
// checks overflow/underflow against the sampled SP and commands the SP update.
module stack_seq
    import stack_seq_pkg::*;
#(
    parameter int                ADDR_W      = 14,
    parameter logic [ADDR_W-1:0] STACK_LIMIT = 14'h3000
) (
    input  logic       clk,
    input  logic       rst_n,
    stack_seq_if.slave bus
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] WR0  = 3'd1;
    localparam logic [2:0] WR1  = 3'd2;
    localparam logic [2:0] RD0  = 3'd3;
    localparam logic [2:0] RD1  = 3'd4;
    localparam logic [2:0] RDW  = 3'd5;
    localparam logic [2:0] ERR  = 3'd6;

    localparam logic [1:0] OP_PUSH8  = 2'd0;
    localparam logic [1:0] OP_PUSH16 = 2'd1;
    localparam logic [1:0] OP_POP8   = 2'd2;
    localparam logic [1:0] OP_POP16  = 2'd3;

    localparam logic [ADDR_W-1:0] ONE_A   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] TWO_A   = {{(ADDR_W-2){1'b0}}, 2'b10};
    localparam logic [ADDR_W:0]   ONE_X   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   TWO_X   = {{(ADDR_W-1){1'b0}}, 2'b10};
    localparam logic [ADDR_W:0]   LIMIT_X = {1'b0, STACK_LIMIT};
    localparam logic [ADDR_W:0]   TOP_X   = {1'b0, {ADDR_W{1'b1}}};

    // Bounds check done one bit wider than the address so nothing wraps.
    function automatic logic stack_fault(input logic [1:0] op, input logic [ADDR_W-1:0] s);
        logic [ADDR_W:0] s_x;
        s_x = {1'b0, s};
        case (op)
            OP_PUSH8:  stack_fault = (s_x < LIMIT_X);
            OP_PUSH16: stack_fault = (s_x < (LIMIT_X + ONE_X));
            OP_POP8:   stack_fault = ((s_x + ONE_X) > TOP_X);
            OP_POP16:  stack_fault = ((s_x + TWO_X) > TOP_X);
            default:   stack_fault = 1'b1;
        endcase
    endfunction

    logic [2:0]        state_r,     state_s;
    logic              ready_r,     ready_s;
    logic              done_r,      done_s;
    logic              err_r,       err_s;
    logic              mem_we_r,    mem_we_s;
    logic              mem_re_r,    mem_re_s;
    logic [ADDR_W-1:0] mem_addr_r,  mem_addr_s;
    logic [7:0]        mem_wdata_r, mem_wdata_s;
    sp_operation_t     sp_op_r,     sp_op_s;
    logic [1:0]        op_r,        op_s;
    logic [7:0]        wlo_r,       wlo_s;
    logic [ADDR_W-1:0] sp_r,        sp_s;
    logic [7:0]        lo_r,        lo_s;
    logic [15:0]       rdata_r,     rdata_s;
    logic [15:0]       pop_value_s;

    // Assemble the popped value from the byte arriving now and the captured low byte.
    always_comb begin
        if (op_r == OP_POP16) begin
            pop_value_s = {bus.mem_rdata, lo_r};
        end else begin
            pop_value_s = {8'h00, bus.mem_rdata};
        end
    end

    // Next-state and next-output decode; every output is loaded for the cycle it belongs to.
    always_comb begin
        state_s     = state_r;
        done_s      = 1'b0;
        err_s       = 1'b0;
        mem_we_s    = 1'b0;
        mem_re_s    = 1'b0;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        sp_op_s     = SP_NOP;
        op_s        = op_r;
        wlo_s       = wlo_r;
        sp_s        = sp_r;
        lo_s        = lo_r;
        rdata_s     = rdata_r;
        case (state_r)
            IDLE: begin
                if (bus.req) begin
                    op_s  = bus.op;
                    wlo_s = bus.wdata[7:0];
                    sp_s  = bus.sp_addr;
                    if (stack_fault(bus.op, bus.sp_addr)) begin
                        state_s = ERR;
                        done_s  = 1'b1;
                        err_s   = 1'b1;
                    end else begin
                        case (bus.op)
                            OP_PUSH8: begin
                                state_s     = WR1;
                                mem_we_s    = 1'b1;
                                mem_addr_s  = bus.sp_addr;
                                mem_wdata_s = bus.wdata[7:0];
                                sp_op_s     = SP_DEC_1;
                                done_s      = 1'b1;
                            end
                            OP_PUSH16: begin
                                state_s     = WR0;
                                mem_we_s    = 1'b1;
                                mem_addr_s  = bus.sp_addr;
                                mem_wdata_s = bus.wdata[15:8];
                            end
                            default: begin
                                state_s    = RD0;
                                mem_re_s   = 1'b1;
                                mem_addr_s = bus.sp_addr + ONE_A;
                            end
                        endcase
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WR0: begin
                state_s     = WR1;
                mem_we_s    = 1'b1;
                mem_addr_s  = sp_r - ONE_A;
                mem_wdata_s = wlo_r;
                sp_op_s     = SP_DEC_2;
                done_s      = 1'b1;
            end
            RD0: begin
                state_s = RDW;
                if (op_r == OP_POP16) begin
                    state_s    = RD1;
                    mem_re_s   = 1'b1;
                    mem_addr_s = sp_r + TWO_A;
                end else begin
                    sp_op_s = SP_INC_1;
                    done_s  = 1'b1;
                end
            end
            RD1: begin
                state_s = RDW;
                lo_s    = bus.mem_rdata;
                sp_op_s = SP_INC_2;
                done_s  = 1'b1;
            end
            RDW: begin
                state_s = IDLE;
                rdata_s = pop_value_s;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        ready_s = (state_s == IDLE);
    end

    // State and output registers; reset abandons any op in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            ready_r     <= 1'b1;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_re_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= 8'h00;
            sp_op_r     <= SP_NOP;
            op_r        <= 2'd0;
            wlo_r       <= 8'h00;
            sp_r        <= {ADDR_W{1'b0}};
            lo_r        <= 8'h00;
            rdata_r     <= 16'h0000;
        end else begin
            state_r     <= state_s;
            ready_r     <= ready_s;
            done_r      <= done_s;
            err_r       <= err_s;
            mem_we_r    <= mem_we_s;
            mem_re_r    <= mem_re_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            sp_op_r     <= sp_op_s;
            op_r        <= op_s;
            wlo_r       <= wlo_s;
            sp_r        <= sp_s;
            lo_r        <= lo_s;
            rdata_r     <= rdata_s;
        end
    end

    assign bus.ready        = ready_r;
    assign bus.done         = done_r;
    assign bus.err          = err_r;
    assign bus.mem_we       = mem_we_r;
    assign bus.mem_re       = mem_re_r;
    assign bus.mem_addr     = mem_addr_r;
    assign bus.mem_wdata    = mem_wdata_r;
    assign bus.sp_operation = sp_op_r;
    // Read data only arrives in the done cycle, so the pop result passes straight
    // through then and is held from the register afterwards.
    assign bus.rdata        = (state_r == RDW) ? pop_value_s : rdata_r;

endmodule

// File: tb/tb_stack_seq.sv
// Bench for stack_seq: directed table, back-to-back and reset corner cases,
// then random PUSH/POP traffic against a byte-array stack model.
module tb_stack_seq;
    import stack_seq_pkg::*;

    localparam int         ADDR_W = 14;
    localparam int         LIMIT  = 32'h3000;
    localparam logic [1:0] PUSH8  = 2'd0;
    localparam logic [1:0] PUSH16 = 2'd1;
    localparam logic [1:0] POP8   = 2'd2;
    localparam logic [1:0] POP16  = 2'd3;

    typedef struct {
        logic [1:0]    op;
        logic [15:0]   wdata;
        logic [13:0]   sp_in;
        int            lat;
        logic          err;
        sp_operation_t spop;
        int            nw;
        int            nr;
        logic [13:0]   a0;
        logic [7:0]    d0;
        logic [13:0]   a1;
        logic [7:0]    d1;
        logic [15:0]   rdata;
        logic [13:0]   sp_out;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;

    stack_seq_if #(.ADDR_W(ADDR_W)) bus ();

    stack_seq #(.ADDR_W(ADDR_W), .STACK_LIMIT(14'h3000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  mem  [0:16383];
    logic [7:0]  emem [0:16383];
    logic [13:0] sp_reg;
    logic [15:0] m_rdata;

    logic          s_ready, s_done, s_err, s_we, s_re;
    logic [13:0]   s_addr;
    logic [7:0]    s_wdata;
    logic [15:0]   s_rdata;
    sp_operation_t s_spop;

    int            tr_lat, tr_nw, tr_nr;
    logic          tr_err, tr_bad;
    sp_operation_t tr_spop;
    logic [13:0]   tr_wa [2];
    logic [7:0]    tr_wd [2];
    logic [13:0]   tr_ra [2];
    logic [15:0]   tr_rdata, tr_held;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_sp(input logic [13:0] v);
        sp_reg      = v;
        bus.sp_addr = v;
    endtask

    // One clock: memory and SP react to what was on the bus at the edge, then sample.
    task automatic tick();
        @(posedge clk);
        #1;
        if (s_we === 1'b1) mem[s_addr] = s_wdata;
        if (s_re === 1'b1) bus.mem_rdata = mem[s_addr];
        case (s_spop)
            SP_INC_1: sp_reg = sp_reg + 14'd1;
            SP_INC_2: sp_reg = sp_reg + 14'd2;
            SP_DEC_1: sp_reg = sp_reg - 14'd1;
            SP_DEC_2: sp_reg = sp_reg - 14'd2;
            default:  ;
        endcase
        bus.sp_addr = sp_reg;
        @(negedge clk);
        s_ready = bus.ready;
        s_done  = bus.done;
        s_err   = bus.err;
        s_we    = bus.mem_we;
        s_re    = bus.mem_re;
        s_addr  = bus.mem_addr;
        s_wdata = bus.mem_wdata;
        s_rdata = bus.rdata;
        s_spop  = bus.sp_operation;
    endtask

    // Issue one op from IDLE and record its trace up to the done pulse (bounded).
    task automatic run_op(input logic [1:0] op, input logic [15:0] wd, input logic noise);
        chk("ready_before_op", s_ready, 32'd1);
        bus.req   = 1'b1;
        bus.op    = op;
        bus.wdata = wd;
        tick();
        bus.req  = 1'b0;
        tr_lat   = 0;
        tr_nw    = 0;
        tr_nr    = 0;
        tr_err   = 1'b0;
        tr_bad   = 1'b0;
        tr_spop  = SP_NOP;
        tr_rdata = 16'h0000;
        for (int k = 1; k <= 6; k++) begin
            if (s_we && s_re) tr_bad = 1'b1;
            if (s_ready) tr_bad = 1'b1;
            if (s_we) begin
                if (tr_nw < 2) begin
                    tr_wa[tr_nw] = s_addr;
                    tr_wd[tr_nw] = s_wdata;
                end
                tr_nw++;
            end
            if (s_re) begin
                if (tr_nr < 2) tr_ra[tr_nr] = s_addr;
                tr_nr++;
            end
            if (s_done) begin
                tr_lat   = k;
                tr_err   = s_err;
                tr_spop  = s_spop;
                tr_rdata = s_rdata;
                break;
            end
            if (s_spop != SP_NOP || s_err) tr_bad = 1'b1;
            if (noise) begin
                bus.req   = 1'($urandom);
                bus.op    = 2'($urandom);
                bus.wdata = 16'($urandom);
            end
            tick();
        end
        bus.req = 1'b0;
        tick();
        tr_held = s_rdata;
    endtask

    task automatic check_vec(input vec_t e, input string tag);
        chk({tag, ".latency"}, tr_lat, e.lat);
        chk({tag, ".err"}, {31'd0, tr_err}, {31'd0, e.err});
        chk({tag, ".sp_op"}, {29'd0, tr_spop}, {29'd0, e.spop});
        chk({tag, ".writes"}, tr_nw, e.nw);
        chk({tag, ".reads"}, tr_nr, e.nr);
        if (e.nw >= 1 && tr_nw >= 1) begin
            chk({tag, ".waddr0"}, {18'd0, tr_wa[0]}, {18'd0, e.a0});
            chk({tag, ".wdata0"}, {24'd0, tr_wd[0]}, {24'd0, e.d0});
        end
        if (e.nw == 2 && tr_nw == 2) begin
            chk({tag, ".waddr1"}, {18'd0, tr_wa[1]}, {18'd0, e.a1});
            chk({tag, ".wdata1"}, {24'd0, tr_wd[1]}, {24'd0, e.d1});
        end
        if (e.nr >= 1 && tr_nr >= 1) chk({tag, ".raddr0"}, {18'd0, tr_ra[0]}, {18'd0, e.a0});
        if (e.nr == 2 && tr_nr == 2) chk({tag, ".raddr1"}, {18'd0, tr_ra[1]}, {18'd0, e.a1});
        chk({tag, ".rdata_done"}, {16'd0, tr_rdata}, {16'd0, e.rdata});
        chk({tag, ".rdata_held"}, {16'd0, tr_held}, {16'd0, e.rdata});
        chk({tag, ".sp_after"}, {18'd0, sp_reg}, {18'd0, e.sp_out});
        chk({tag, ".protocol"}, {31'd0, tr_bad}, 32'd0);
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [15:0] wd, input logic [13:0] sp_in,
                                input int lat, input logic err, input sp_operation_t spop,
                                input int nw, input int nr, input logic [13:0] a0, input logic [7:0] d0,
                                input logic [13:0] a1, input logic [7:0] d1,
                                input logic [15:0] rdata, input logic [13:0] sp_out);
        vec_t v;
        v.op = op; v.wdata = wd; v.sp_in = sp_in; v.lat = lat; v.err = err; v.spop = spop;
        v.nw = nw; v.nr = nr; v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
        v.rdata = rdata; v.sp_out = sp_out;
        return v;
    endfunction

    // Stack semantics on a byte array: push stores high byte first at S, pop reads upward.
    task automatic predict(input logic [1:0] op, input logic [15:0] wd, input logic [13:0] s, output vec_t e);
        int n;
        int si;
        n  = (op == PUSH16 || op == POP16) ? 2 : 1;
        si = int'(s);
        e.op = op; e.wdata = wd; e.sp_in = s; e.nw = 0; e.nr = 0;
        e.a0 = 14'd0; e.a1 = 14'd0; e.d0 = 8'd0; e.d1 = 8'd0;
        e.spop = SP_NOP; e.err = 1'b0; e.sp_out = s; e.lat = 1;
        if (op == PUSH8 || op == PUSH16) begin
            if (si - (n - 1) < LIMIT) begin
                e.err = 1'b1;
            end else begin
                e.nw = n;
                e.a0 = s;
                e.d0 = (n == 2) ? wd[15:8] : wd[7:0];
                emem[e.a0] = e.d0;
                if (n == 2) begin
                    e.a1 = 14'(si - 1);
                    e.d1 = wd[7:0];
                    emem[e.a1] = e.d1;
                    e.spop = SP_DEC_2;
                end else begin
                    e.spop = SP_DEC_1;
                end
                e.lat    = n;
                e.sp_out = 14'(si - n);
            end
        end else begin
            if (si + n > 16383) begin
                e.err = 1'b1;
            end else begin
                e.nr = n;
                e.a0 = 14'(si + 1);
                if (n == 2) begin
                    e.a1    = 14'(si + 2);
                    m_rdata = {emem[e.a1], emem[e.a0]};
                    e.spop  = SP_INC_2;
                end else begin
                    m_rdata = {8'h00, emem[e.a0]};
                    e.spop  = SP_INC_1;
                end
                e.lat    = n + 1;
                e.sp_out = 14'(si + n);
            end
        end
        e.rdata = m_rdata;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [13:0] b2b_addr [3];
        int          nb;

        s_ready = 1'b0; s_done = 1'b0; s_err = 1'b0; s_we = 1'b0; s_re = 1'b0;
        s_addr = 14'd0; s_wdata = 8'd0; s_rdata = 16'd0; s_spop = SP_NOP;
        for (int a = 0; a < 16384; a++) mem[a] = 8'h00;
        rst_n = 1'b0;
        bus.req = 1'b0; bus.op = 2'd0; bus.wdata = 16'h0000; bus.mem_rdata = 8'h00;
        set_sp(14'h3FFF);
        tick();
        tick();
        chk("rst.ready", {31'd0, s_ready}, 32'd1);
        chk("rst.done", {31'd0, s_done}, 32'd0);
        chk("rst.err", {31'd0, s_err}, 32'd0);
        chk("rst.we_re", {30'd0, s_we, s_re}, 32'd0);
        chk("rst.addr_wdata", {10'd0, s_addr, s_wdata}, 32'd0);
        chk("rst.rdata", {16'd0, s_rdata}, 32'd0);
        chk("rst.sp_op", {29'd0, s_spop}, {29'd0, SP_NOP});
        rst_n = 1'b1;
        tick();

        // Directed table
        tbl[0]  = mk(PUSH16, 16'h1234, 14'h3FFF, 2, 1'b0, SP_DEC_2, 2, 0, 14'h3FFF, 8'h12, 14'h3FFE, 8'h34, 16'h0000, 14'h3FFD);
        tbl[1]  = mk(POP16,  16'h0000, 14'h3FFD, 3, 1'b0, SP_INC_2, 0, 2, 14'h3FFE, 8'h00, 14'h3FFF, 8'h00, 16'h1234, 14'h3FFF);
        tbl[2]  = mk(POP8,   16'h0000, 14'h3FFF, 1, 1'b1, SP_NOP,   0, 0, 14'h0000, 8'h00, 14'h0000, 8'h00, 16'h1234, 14'h3FFF);
        tbl[3]  = mk(PUSH16, 16'hABCD, 14'h3000, 1, 1'b1, SP_NOP,   0, 0, 14'h0000, 8'h00, 14'h0000, 8'h00, 16'h1234, 14'h3000);
        tbl[4]  = mk(PUSH8,  16'h00AB, 14'h3000, 1, 1'b0, SP_DEC_1, 1, 0, 14'h3000, 8'hAB, 14'h0000, 8'h00, 16'h1234, 14'h2FFF);
        tbl[5]  = mk(POP8,   16'h0000, 14'h2FFF, 2, 1'b0, SP_INC_1, 0, 1, 14'h3000, 8'h00, 14'h0000, 8'h00, 16'h00AB, 14'h3000);
        tbl[6]  = mk(PUSH16, 16'hBEEF, 14'h3001, 2, 1'b0, SP_DEC_2, 2, 0, 14'h3001, 8'hBE, 14'h3000, 8'hEF, 16'h00AB, 14'h2FFF);
        tbl[7]  = mk(POP16,  16'h0000, 14'h2FFF, 3, 1'b0, SP_INC_2, 0, 2, 14'h3000, 8'h00, 14'h3001, 8'h00, 16'hBEEF, 14'h3001);
        tbl[8]  = mk(POP16,  16'h0000, 14'h3FFE, 1, 1'b1, SP_NOP,   0, 0, 14'h0000, 8'h00, 14'h0000, 8'h00, 16'hBEEF, 14'h3FFE);
        tbl[9]  = mk(POP8,   16'h0000, 14'h3FFE, 2, 1'b0, SP_INC_1, 0, 1, 14'h3FFF, 8'h00, 14'h0000, 8'h00, 16'h0012, 14'h3FFF);
        tbl[10] = mk(PUSH8,  16'h0055, 14'h2FFF, 1, 1'b1, SP_NOP,   0, 0, 14'h0000, 8'h00, 14'h0000, 8'h00, 16'h0012, 14'h2FFF);
        tbl[11] = mk(POP16,  16'h0000, 14'h3FFD, 3, 1'b0, SP_INC_2, 0, 2, 14'h3FFE, 8'h00, 14'h3FFF, 8'h00, 16'h1234, 14'h3FFF);
        for (int i = 0; i < 12; i++) begin
            set_sp(tbl[i].sp_in);
            run_op(tbl[i].op, tbl[i].wdata, 1'b0);
            check_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Back-to-back PUSH8 with req held high
        set_sp(14'h3FFF);
        nb = 0;
        for (int i = 0; i < 3; i++) b2b_addr[i] = 14'd0;
        bus.req = 1'b1; bus.op = PUSH8; bus.wdata = 16'h5A77;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 6) bus.req = 1'b0;
            chk($sformatf("b2b.ready_c%0d", c), {31'd0, s_ready}, (c % 2 == 0) ? 32'd1 : 32'd0);
            if (s_we) begin
                if (nb < 3) b2b_addr[nb] = s_addr;
                nb++;
            end
        end
        chk("b2b.writes", nb, 32'd3);
        chk("b2b.addr0", {18'd0, b2b_addr[0]}, 32'h3FFF);
        chk("b2b.addr1", {18'd0, b2b_addr[1]}, 32'h3FFE);
        chk("b2b.addr2", {18'd0, b2b_addr[2]}, 32'h3FFD);
        chk("b2b.sp", {18'd0, sp_reg}, 32'h3FFC);
        tick();
        chk("b2b.no_extra", {30'd0, s_we, s_ready}, 32'd1);

        // Reset during POP16 second read
        set_sp(14'h3FFD);
        bus.req = 1'b1; bus.op = POP16;
        tick();
        bus.req = 1'b0;
        chk("rstmid.c1", {13'd0, s_re, s_we, s_addr, 2'd0}, {13'd0, 1'b1, 1'b0, 14'h3FFE, 2'd0});
        tick();
        chk("rstmid.c2", {13'd0, s_re, s_we, s_addr, 2'd0}, {13'd0, 1'b1, 1'b0, 14'h3FFF, 2'd0});
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rstmid.ready", {31'd0, s_ready}, 32'd1);
        chk("rstmid.done", {30'd0, s_done, s_err}, 32'd0);
        chk("rstmid.sp_op", {29'd0, s_spop}, {29'd0, SP_NOP});
        chk("rstmid.strobes", {30'd0, s_we, s_re}, 32'd0);
        chk("rstmid.rdata", {16'd0, s_rdata}, 32'd0);
        tick();
        chk("rstmid.quiet", {29'd0, s_done, s_re, s_ready}, 32'd1);
        chk("rstmid.sp", {18'd0, sp_reg}, 32'h3FFD);

        // Random traffic against the stack model
        m_rdata = 16'h0000;
        for (int a = 0; a < 16384; a++) begin
            mem[a]  = 8'($urandom);
            emem[a] = mem[a];
        end
        for (int i = 0; i < 200; i++) begin
            vec_t        e;
            logic [1:0]  rop;
            logic [15:0] rwd;
            if ($urandom_range(0, 4) == 0) begin
                case ($urandom_range(0, 7))
                    0:       set_sp(14'h3000);
                    1:       set_sp(14'h3001);
                    2:       set_sp(14'h2FFF);
                    3:       set_sp(14'h3FFF);
                    4:       set_sp(14'h3FFE);
                    5:       set_sp(14'h3FFD);
                    default: set_sp(14'($urandom_range(32'h3000, 32'h3FFF)));
                endcase
            end
            rop = 2'($urandom_range(0, 3));
            rwd = 16'($urandom);
            predict(rop, rwd, sp_reg, e);
            run_op(rop, rwd, 1'b1);
            check_vec(e, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
